// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG initiator.
// Runs TAP reset, IR shift, DR shift and Run-Test/Idle clock sequences on
// the JTAG pads. Commands and responses use valid/ready handshakes.
//   clk_p, rstn         system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake; cmd_op, cmd_len, cmd_data payload
//   rsp_valid/rsp_ready response handshake; rsp_data captured TDO bits
//   busy                sequence in progress
//   tck_o, tms_o, tdi_o, tdo_i, trstn_o   JTAG pads
module jtag_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7
) (
  input  logic               clk_p,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               trstn_o
);
  localparam int unsigned PH_W  = $clog2(2 * CLK_DIV);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]  PH_PRE  = PH_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, RST_SEQ, SEL, SHIFT, EXIT, RTI_WAIT, RESP} state_e;
  typedef enum logic [1:0] {OP_RST = 2'b00, OP_IR = 2'b01, OP_DR = 2'b10, OP_RTI = 2'b11} op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               init_q;
  logic [LEN_W-1:0]   last_idx;
  logic               running;

  // TMS for TCK number idx within a state, TAP assumed to start in Run-Test/Idle.
  function automatic logic tms_at(input state_e st, input logic [LEN_W-1:0] idx,
                                  input op_e op, input logic [LEN_W-1:0] len);
    tms_at = 1'b0;
    case (st)
      RST_SEQ: tms_at = (idx < LEN_W'(5));
      SEL:     tms_at = (op == OP_IR) ? (idx < LEN_W'(2)) : (idx == '0);
      SHIFT:   tms_at = (idx == len - LEN_W'(1));
      EXIT:    tms_at = (idx == '0);
      default: tms_at = 1'b0;
    endcase
  endfunction

  assign running   = (state_q != IDLE) && (state_q != RESP);
  assign cmd_ready = (state_q == IDLE) && init_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_q;
  assign busy      = running;
  assign tck_o     = running && (ph_q >= PH_HIGH);
  assign tms_o     = tms_q;
  assign tdi_o     = tdi_q;
  assign trstn_o   = init_q && (state_q != RST_SEQ);

  always_comb begin
    last_idx = '0;
    case (state_q)
      RST_SEQ:         last_idx = LEN_W'(5);
      SEL:             last_idx = (op_q == OP_IR) ? LEN_W'(3) : LEN_W'(2);
      SHIFT, RTI_WAIT: last_idx = len_q - LEN_W'(1);
      EXIT:            last_idx = LEN_W'(1);
      default:         last_idx = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = op_e'(cmd_op);
          data_d = cmd_data;
          rsp_d  = '0;
          ph_d   = '0;
          cnt_d  = '0;
          case (op_d)
            OP_RST:       state_d = RST_SEQ;
            OP_IR, OP_DR: state_d = SEL;
            default:      state_d = RTI_WAIT;
          endcase
          if (op_d == OP_RTI)      len_d = cmd_len;
          else if (cmd_len == '0)  len_d = LEN_W'(1);
          else if (cmd_len > MAX_L) len_d = MAX_L;
          else                     len_d = cmd_len;
          tms_d = tms_at(state_d, '0, op_d, len_d);
          tdi_d = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        if (state_q == RTI_WAIT && len_q == '0) begin
          state_d = RESP;
        end else if (ph_q == PH_LAST) begin
          // Period boundary: TCK falls here, so TMS/TDI for the next bit load now.
          ph_d = '0;
          if (cnt_q == last_idx) begin
            cnt_d = '0;
            case (state_q)
              SEL:     state_d = SHIFT;
              SHIFT:   state_d = EXIT;
              default: state_d = RESP;
            endcase
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
          tms_d = tms_at(state_d, cnt_d, op_q, len_q);
          tdi_d = (state_d == SHIFT) ? data_q[cnt_d[IDX_W-1:0]] : 1'b0;
        end else begin
          ph_d = ph_q + PH_W'(1);
          // TCK rises on this edge; capture TDO for the current shift bit.
          if (state_q == SHIFT && ph_q == PH_PRE) rsp_d[cnt_q[IDX_W-1:0]] = tdo_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk_p or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      op_q    <= OP_RST;
      ph_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      init_q  <= 1'b1;
    end
  end
endmodule
